// File: rtl/traffic_conflict_monitor_if.sv
// Lamp request / lamp drive bundle between an intersection controller and
// the traffic_conflict_monitor safety stage.
interface traffic_conflict_monitor_if;
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic clear_fault;
    logic ns_red_o;
    logic ns_yellow_o;
    logic ns_green_o;
    logic ew_red_o;
    logic ew_yellow_o;
    logic ew_green_o;
    logic fault;
    logic [1:0] fault_code;

    // Controller side: issues lamp requests and fault clears, watches drives.
    modport master (
        output ns_red, ns_yellow, ns_green,
        output ew_red, ew_yellow, ew_green,
        output clear_fault,
        input  ns_red_o, ns_yellow_o, ns_green_o,
        input  ew_red_o, ew_yellow_o, ew_green_o,
        input  fault, fault_code
    );

    // Monitor side: checks requests and produces the lamp drives.
    modport slave (
        input  ns_red, ns_yellow, ns_green,
        input  ew_red, ew_yellow, ew_green,
        input  clear_fault,
        output ns_red_o, ns_yellow_o, ns_green_o,
        output ew_red_o, ew_yellow_o, ew_green_o,
        output fault, fault_code
    );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Traffic conflict monitor: passes legal lamp requests through with one cycle
// of latency, forces all-red on illegal requests, and latches a flashing-red
// FAULT state after FAULT_FILTER consecutive illegal cycles.
// Optional feature macro: MON_SEQUENCE_CHECK_EN adds green->red and
// short-yellow->red sequence checking (fault_code 10).
module traffic_conflict_monitor #(
    parameter int STARTUP_CYCLES    = 3,
    parameter int FAULT_FILTER      = 2,
    parameter int FLASH_HALF_PERIOD = 4,
    parameter int MIN_YELLOW        = 2
) (
    input logic clk,
    input logic reset,
    traffic_conflict_monitor_if.slave bus
);
    typedef enum logic [1:0] {STARTUP, PASS, FAULT} state_t;

    localparam logic [1:0]  CODE_NONE     = 2'b00;
    localparam logic [1:0]  CODE_CONFLICT = 2'b01;
    localparam logic [1:0]  CODE_SEQUENCE = 2'b10;
    localparam logic [15:0] STARTUP_LAST  = 16'(STARTUP_CYCLES - 1);
    localparam logic [3:0]  FILTER_LIMIT  = 4'(FAULT_FILTER);
    localparam logic [7:0]  FLASH_LAST    = 8'(FLASH_HALF_PERIOD - 1);
    localparam logic [2:0]  LAMP_RED      = 3'b100;

    state_t      state;
    logic [15:0] startup_cnt;
    logic [3:0]  filter_cnt;
    logic [7:0]  flash_cnt;
    logic        flash;
    logic [2:0]  ns_lamp;   // {red, yellow, green}
    logic [2:0]  ew_lamp;
    logic        fault_q;
    logic [1:0]  code_q;

    logic [2:0]  ns_in;
    logic [2:0]  ew_in;
    logic        legal;
    logic        seq_err;
    logic        clear_req;

    assign ns_in = {bus.ns_red, bus.ns_yellow, bus.ns_green};
    assign ew_in = {bus.ew_red, bus.ew_yellow, bus.ew_green};
    assign legal = $onehot(ns_in) && $onehot(ew_in) && (ns_in[2] || ew_in[2]);
    // A fault clear re-enters STARTUP exactly as a reset would.
    assign clear_req = (state == FAULT) && bus.clear_fault && legal;

`ifdef MON_SEQUENCE_CHECK_EN
    localparam logic [7:0] MIN_YELLOW_L = 8'(MIN_YELLOW);

    // Last legal lamp seen in PASS per direction; 000 means no history yet.
    logic [2:0] ns_prev;
    logic [2:0] ew_prev;
    logic [7:0] ns_yrun;
    logic [7:0] ew_yrun;

    function automatic logic seq_violation(input logic [2:0] cur, input logic [2:0] prev,
                                           input logic [7:0] yrun);
        return cur[2] && (prev[0] || (prev[1] && (yrun < MIN_YELLOW_L)));
    endfunction

    function automatic logic [7:0] next_yrun(input logic [2:0] cur, input logic [2:0] prev,
                                             input logic [7:0] yrun);
        if (!cur[1])
            return 8'd0;
        if (!prev[1])
            return 8'd1;
        return (yrun == 8'hFF) ? yrun : yrun + 8'd1;
    endfunction

    assign seq_err = seq_violation(ns_in, ns_prev, ns_yrun) ||
                     seq_violation(ew_in, ew_prev, ew_yrun);
`else
    logic unused_min_yellow;
    assign unused_min_yellow = ^MIN_YELLOW;
    assign seq_err = 1'b0;
`endif

    // Monitor FSM with registered lamp drives, fault flag and counters.
    always_ff @(posedge clk) begin
        if (reset || clear_req) begin
            state       <= STARTUP;
            startup_cnt <= '0;
            filter_cnt  <= '0;
            flash_cnt   <= '0;
            flash       <= 1'b0;
            ns_lamp     <= LAMP_RED;
            ew_lamp     <= LAMP_RED;
            fault_q     <= 1'b0;
            code_q      <= CODE_NONE;
`ifdef MON_SEQUENCE_CHECK_EN
            ns_prev     <= '0;
            ew_prev     <= '0;
            ns_yrun     <= '0;
            ew_yrun     <= '0;
`endif
        end else begin
            case (state)
                STARTUP: begin
                    ns_lamp <= LAMP_RED;
                    ew_lamp <= LAMP_RED;
                    if (startup_cnt == STARTUP_LAST) begin
                        state       <= PASS;
                        startup_cnt <= '0;
                    end else begin
                        startup_cnt <= startup_cnt + 16'd1;
                    end
                end
                PASS: begin
                    // A filter already at its limit wins over a same-cycle sequence error.
                    if ((filter_cnt >= FILTER_LIMIT) || (legal && seq_err)) begin
                        state     <= FAULT;
                        fault_q   <= 1'b1;
                        code_q    <= (filter_cnt >= FILTER_LIMIT) ? CODE_CONFLICT : CODE_SEQUENCE;
                        flash     <= 1'b1;
                        flash_cnt <= '0;
                        ns_lamp   <= LAMP_RED;
                        ew_lamp   <= LAMP_RED;
                    end else if (legal) begin
                        ns_lamp    <= ns_in;
                        ew_lamp    <= ew_in;
                        filter_cnt <= '0;
`ifdef MON_SEQUENCE_CHECK_EN
                        ns_prev    <= ns_in;
                        ew_prev    <= ew_in;
                        ns_yrun    <= next_yrun(ns_in, ns_prev, ns_yrun);
                        ew_yrun    <= next_yrun(ew_in, ew_prev, ew_yrun);
`endif
                    end else begin
                        ns_lamp <= LAMP_RED;
                        ew_lamp <= LAMP_RED;
                        if (filter_cnt != FILTER_LIMIT)
                            filter_cnt <= filter_cnt + 4'd1;
                    end
                end
                FAULT: begin
                    if (flash_cnt == FLASH_LAST) begin
                        flash_cnt <= '0;
                        flash     <= ~flash;
                        ns_lamp   <= {~flash, 2'b00};
                        ew_lamp   <= {~flash, 2'b00};
                    end else begin
                        flash_cnt <= flash_cnt + 8'd1;
                        ns_lamp   <= {flash, 2'b00};
                        ew_lamp   <= {flash, 2'b00};
                    end
                end
                default: state <= STARTUP;
            endcase
        end
    end

    assign bus.ns_red_o    = ns_lamp[2];
    assign bus.ns_yellow_o = ns_lamp[1];
    assign bus.ns_green_o  = ns_lamp[0];
    assign bus.ew_red_o    = ew_lamp[2];
    assign bus.ew_yellow_o = ew_lamp[1];
    assign bus.ew_green_o  = ew_lamp[0];
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;
endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter STARTUP_CYCLES, default 3, all-red hold length in cycles after reset or after a fault clear.
REQ-002 Parameter FAULT_FILTER, default 2, consecutive illegal input cycles that trigger a conflict fault; range 1..15.
REQ-003 Parameter FLASH_HALF_PERIOD, default 4, cycles per flash phase in FAULT; range 1..255.
REQ-004 Parameter MIN_YELLOW, default 2, minimum consecutive yellow cycles before red; used only with the sequence-check macro.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ns_red, ns_yellow, ns_green  input  1 each  NS lamp requests from the intersection controller.
REQ-008 ew_red, ew_yellow, ew_green  input  1 each  EW lamp requests from the intersection controller.
REQ-009 clear_fault  input  1  operator request to leave FAULT.
REQ-010 ns_red_o, ns_yellow_o, ns_green_o, ew_red_o, ew_yellow_o, ew_green_o  output  1 each  registered lamp drives.
REQ-011 fault  output  1  high while in FAULT.
REQ-012 fault_code  output  2  00 none, 01 conflict, 10 sequence, 11 unused.

Function
REQ-013 Legal input: each direction's lamp triple is one-hot, and at least one direction is red.
REQ-014 FSM states: STARTUP, PASS, FAULT. All outputs are registered, with one cycle of latency from input to output.
REQ-015 STARTUP drives all-red (both reds 1, other lamps 0) for exactly STARTUP_CYCLES cycles, then enters PASS. Inputs are not checked.
REQ-016 In PASS with a legal input, the outputs copy that input on the next cycle.
REQ-017 In PASS with an illegal input, the outputs drive all-red on the next cycle, and a 4-bit filter counter increments.
REQ-018 Any legal input cycle clears the filter counter to 0.
REQ-019 When the filter counter reaches FAULT_FILTER, the FSM enters FAULT on the next edge with fault_code=01. The counter saturates and does not wrap.
REQ-020 In FAULT: green and yellow outputs are 0, and both reds equal the flash bit. The flash bit is 1 on the first FAULT cycle and toggles every FLASH_HALF_PERIOD cycles. The 8-bit flash counter wraps to 0 at each toggle.
REQ-021 fault=1 and fault_code hold their value for the whole of FAULT.
REQ-022 In FAULT, clear_fault=1 together with a legal input moves to STARTUP on the next edge, clearing fault, fault_code and the counters. clear_fault with an illegal input is ignored.
REQ-023 clear_fault is ignored in STARTUP and PASS.
REQ-024 If a conflict and a sequence fault occur in the same cycle, fault_code=01.

Reset
REQ-025 reset takes priority over all other inputs, including mid-FAULT and mid-STARTUP.
REQ-026 Reset values: state=STARTUP, both reds 1, all other lamp outputs 0, fault=0, fault_code=00, all counters 0, yellow-tracking history cleared.
REQ-027 The STARTUP count begins on the first cycle after reset deasserts.

Configuration
REQ-028 Macro MON_SEQUENCE_CHECK_EN.
REQ-029 When defined, PASS tracks per direction the previous legal lamp and a saturating yellow-run counter.
REQ-030 When defined, a green-to-red input transition, or a yellow-to-red transition with yellow run < MIN_YELLOW, enters FAULT immediately on the next edge with code 10. FAULT_FILTER does not apply.
REQ-031 When not defined, the sequence logic is absent, fault_code 10 never occurs, and MIN_YELLOW is unused.

Verification
REQ-032 Reset, then legal NS-green/EW-red held: outputs all-red for 3 cycles, then ns_green_o=1 and ew_red_o=1 with 1-cycle latency; fault=0.
REQ-033 In PASS, drive ns_green=ew_green=1 for 1 cycle, then legal: outputs all-red for 1 cycle, then follow the input; no fault.
REQ-034 In PASS, drive ns_green=ew_green=1 for 2 cycles: fault=1 and fault_code=01; reds flash 4 cycles on, 4 off; greens and yellows stay 0.
REQ-035 In FAULT, clear_fault=1 with an illegal input gives no change. clear_fault=1 with a legal input gives STARTUP (3 all-red cycles), then PASS, with fault=0.
REQ-036 With MON_SEQUENCE_CHECK_EN: NS yellow for 1 cycle then red gives fault_code=10 on the next edge. NS yellow for 2 cycles then red gives no fault. Without the macro, the 1-cycle case gives no fault.
REQ-037 Assert reset mid-FAULT: next cycle shows the reset values, and the 3-cycle STARTUP restarts.
